// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the MEM-stage data-memory access controller.
package mem_ctrl_pkg;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Value returned to the MEM-stage register when an access is aborted
    localparam logic [31:0] ABORT_RDATA = 32'h0;

    // Default memory mapping and ack timeout
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
    localparam int          DEFAULT_TIMEOUT   = 255;

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// Wait-cycle counter for the BUSY state; terminal_o flags the last permitted wait cycle.
module wait_counter #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Clear has priority over counting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign terminal_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: req/ack handshake, pipeline freeze, load return, timeout abort.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          TIMEOUT   = DEFAULT_TIMEOUT,
    parameter int          CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_en_in,
    input  logic              MEM_W_en_in,
    input  logic [31:0]       Addr_in,
    input  logic [31:0]       Wdata_in,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              freeze,
    output logic              ready,
    output logic [31:0]       Mem_read_value,
    output logic              timeout_err
);

    logic [1:0]        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic [31:0]       rval_q, rval_d;
    logic              terr_q, terr_d;

    logic              access;
    logic [ADDR_W-1:0] word_addr;
    logic              cnt_clear, cnt_enable, cnt_terminal;

    assign access    = MEM_R_en_in | MEM_W_en_in;
    // Byte offset from the memory base, converted to a word index; low two bits drop out
    assign word_addr = ADDR_W'((Addr_in - BASE_ADDR) >> 2);

    wait_counter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (cnt_clear),
        .enable_i   (cnt_enable),
        .terminal_o (cnt_terminal)
    );

    // Next-state and output-register logic of the access sequencer
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ready_d    = 1'b0;
        rval_d     = rval_q;
        terr_d     = terr_q;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    addr_d    = word_addr;
                    wdata_d   = Wdata_in;
                    // A simultaneous load and store is treated as a load
                    we_d      = MEM_W_en_in & ~MEM_R_en_in;
                    req_d     = 1'b1;
                    cnt_clear = 1'b1;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    req_d   = 1'b0;
                    ready_d = 1'b1;
                    if (!we_q) begin
                        rval_d = mem_rdata;
                    end
                    state_d = ST_DONE;
                end else if (cnt_terminal) begin
                    req_d   = 1'b0;
                    ready_d = 1'b1;
                    rval_d  = ABORT_RDATA;
                    terr_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
            ST_DONE: begin
                // Inputs here still belong to the finished instruction
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            rval_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            rval_q  <= rval_d;
            terr_q  <= terr_d;
        end
    end

    // Freeze is held low during reset so the pipeline is not stalled by it
    assign freeze = rst & (((state_q == ST_IDLE) & access) | (state_q == ST_BUSY));

    assign mem_req        = req_q;
    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign ready          = ready_q;
    assign Mem_read_value = rval_q;
    assign timeout_err    = terr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus randomized accesses against a cycle-count model.
module tb_mem_access_ctrl;

    localparam int          ADDR_W = 16;
    localparam logic [31:0] BASE   = 32'd1024;
    localparam int          TO     = 4;
    localparam int          CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              MEM_R_en_in, MEM_W_en_in;
    logic [31:0]       Addr_in, Wdata_in;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              freeze, ready;
    logic [31:0]       Mem_read_value;
    logic              timeout_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: last load result and sticky abort flag
    logic [31:0] m_rval;
    logic        m_terr;

    mem_access_ctrl #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE),
        .TIMEOUT   (TO),
        .CNT_W     (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .MEM_R_en_in    (MEM_R_en_in),
        .MEM_W_en_in    (MEM_W_en_in),
        .Addr_in        (Addr_in),
        .Wdata_in       (Wdata_in),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .freeze         (freeze),
        .ready          (ready),
        .Mem_read_value (Mem_read_value),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".mem_req"}, 32'(mem_req), 32'd0);
        check({tag, ".mem_we"}, 32'(mem_we), 32'd0);
        check({tag, ".mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, ".mem_wdata"}, mem_wdata, 32'd0);
        check({tag, ".ready"}, 32'(ready), 32'd0);
        check({tag, ".rval"}, Mem_read_value, 32'd0);
        check({tag, ".terr"}, 32'(timeout_err), 32'd0);
        check({tag, ".freeze"}, 32'(freeze), 32'd0);
    endtask

    // One instruction in MEM: ack_at = request cycle number carrying the ack, 0 = never ack
    task automatic run_access(input string name, input bit rd, input bit wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int ack_at, input logic [31:0] rdata);
        logic [31:0] off, exp_addr, new_rval;
        bit          exp_we, new_terr;
        int          end_c;
        off      = addr - BASE;
        exp_addr = (off / 4) % 65536;
        exp_we   = wr && !rd;
        end_c    = (ack_at == 0) ? TO : ack_at;
        new_rval = (ack_at == 0) ? 32'd0 : (exp_we ? m_rval : rdata);
        new_terr = m_terr || (ack_at == 0);
        @(posedge clk); #1;
        MEM_R_en_in = rd;
        MEM_W_en_in = wr;
        Addr_in     = addr;
        Wdata_in    = wdata;
        for (int c = 0; c <= end_c + 1; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            mem_ack   = (ack_at != 0) && (c == ack_at);
            mem_rdata = mem_ack ? rdata : $urandom;
            @(negedge clk);
            check({name, ".freeze"}, 32'(freeze), 32'(c <= end_c));
            check({name, ".mem_req"}, 32'(mem_req), 32'(c >= 1 && c <= end_c));
            check({name, ".ready"}, 32'(ready), 32'(c == end_c + 1));
            if (c >= 1 && c <= end_c) begin
                check({name, ".mem_addr"}, 32'(mem_addr), exp_addr);
                check({name, ".mem_we"}, 32'(mem_we), 32'(exp_we));
                check({name, ".mem_wdata"}, mem_wdata, wdata);
            end
            check({name, ".rval"}, Mem_read_value, (c <= end_c) ? m_rval : new_rval);
            check({name, ".terr"}, 32'(timeout_err), 32'((c <= end_c) ? m_terr : new_terr));
        end
        m_rval = new_rval;
        m_terr = new_terr;
        $display("%s: rd=%0b wr=%0b addr=%h word=%h ack_at=%0d rval=%h terr=%0b",
                 name, rd, wr, addr, exp_addr, ack_at, m_rval, m_terr);
    endtask

    // Cycles with no access; an optional stray ack in the first cycle must be ignored
    task automatic idle_cycles(input string name, input int n, input bit stray_ack);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            MEM_R_en_in = 1'b0;
            MEM_W_en_in = 1'b0;
            mem_ack     = stray_ack && (c == 0);
            mem_rdata   = $urandom;
            @(negedge clk);
            check({name, ".freeze"}, 32'(freeze), 32'd0);
            check({name, ".mem_req"}, 32'(mem_req), 32'd0);
            check({name, ".ready"}, 32'(ready), 32'd0);
            check({name, ".rval"}, Mem_read_value, m_rval);
            check({name, ".terr"}, 32'(timeout_err), 32'(m_terr));
        end
        $display("%s: %0d idle cycles stray_ack=%0b", name, n, stray_ack);
    endtask

    initial begin
        rst         = 1'b0;
        MEM_R_en_in = 1'b0;
        MEM_W_en_in = 1'b0;
        Addr_in     = '0;
        Wdata_in    = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        m_rval      = '0;
        m_terr      = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_init");
        $display("reset_init: outputs checked in reset");
        rst = 1'b1;

        run_access("load", 1'b1, 1'b0, 32'd1036, 32'hDEAD_BEEF, 3, 32'hA5A5_0001);
        idle_cycles("gap1", 1, 1'b0);
        run_access("store", 1'b0, 1'b1, 32'd1024, 32'h1234_5678, 1, 32'hFFFF_0000);
        run_access("b2b_load", 1'b1, 1'b0, 32'd1100, 32'h0, 1, 32'h0BAD_F00D);
        run_access("b2b_store", 1'b0, 1'b1, 32'd1203, 32'hCAFE_0042, 1, 32'h1111_2222);
        run_access("both_en", 1'b1, 1'b1, 32'd1028, 32'h5555_AAAA, 2, 32'h7777_8888);
        idle_cycles("stray", 2, 1'b1);

        // Reset in the middle of a pending load
        @(posedge clk); #1;
        MEM_R_en_in = 1'b1;
        Addr_in     = 32'd2000;
        Wdata_in    = 32'h9999_0000;
        mem_ack     = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rst.req_before", 32'(mem_req), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("mid_rst");
        MEM_R_en_in = 1'b0;
        m_rval      = '0;
        m_terr      = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        $display("mid_rst: async reset during BUSY");
        idle_cycles("post_rst_ack", 2, 1'b1);

        run_access("timeout", 1'b1, 1'b0, 32'd1500, 32'h0, 0, 32'h0);
        idle_cycles("late_ack", 2, 1'b1);
        run_access("after_to", 1'b1, 1'b0, 32'd1032, 32'h0, 2, 32'h3C3C_4D4D);

        for (int i = 0; i < 16; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            run_access($sformatf("rand%0d", i), kind != 1, kind != 0, $urandom, $urandom,
                       $urandom_range(0, TO), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                idle_cycles($sformatf("rgap%0d", i), 1, $urandom_range(0, 1) == 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
